hdmi_audio_pacer: RTL and testbench
===================================

// Module: hdmi_audio_pacer
//
// PURPOSE
//   Rate-accurate audio sample pacer that feeds the hdmi core. It accepts
//   multichannel PCM words from the sound engine, buffers them in a FIFO and
//   releases one frame per audio period. The audio clock is generated by a
//   fractional (NCO) divider, so the long-term audio rate is exact for any
//   CLK_HZ/AUDIO_RATE ratio, not only integer ratios.
//   It sits in the pixel-clock domain, between the clock-domain-crossing
//   registers and the hdmi instance.
//
// PARAMETERS
//   CLK_HZ      27000000  frequency of clk in Hz
//   AUDIO_RATE  32000     output sample rate in Hz
//   CHANNELS    2         number of audio channels; 1..8
//   IN_WIDTH    16        width of each input sample (two's complement)
//   OUT_WIDTH   16        width of each output sample; 16..24
//   FIFO_DEPTH  8         FIFO depth in frames; power of two, >= 2
//   ACC_WIDTH   32        NCO accumulator width; must hold CLK_HZ + 2*AUDIO_RATE
//
// PORTS
//   clk         in   1                      pixel clock; the only clock
//   resetn      in   1                      asynchronous, active-low reset
//   in_valid    in   1                      in_data holds a frame
//   in_ready    out  1                      FIFO not full; combinational (!full)
//   in_data     in   CHANNELS*IN_WIDTH      channel 0 in the LSBs
//   out_sample  out  CHANNELS*OUT_WIDTH     registered frame presented to hdmi
//   clk_audio   out  1                      registered audio clock, AUDIO_RATE Hz
//   sample_tick out  1                      1-cycle pulse when out_sample updates
//   fifo_level  out  $clog2(FIFO_DEPTH)+1   frames currently stored
//   underrun    out  1                      sticky: a pop found the FIFO empty
//   overrun     out  1                      sticky: in_valid && !in_ready seen
//   clear_flags in   1                      synchronous clear of both sticky flags
//
// BEHAVIOUR
//   Reset values
//   - acc=0, clk_audio=0, out_sample=0, sample_tick=0, fifo_level=0,
//     underrun=0, overrun=0, in_ready=1.
//   - Reset mid-operation discards all buffered frames.
//
//   NCO
//   - Each cycle: acc += 2*AUDIO_RATE.
//   - If the sum is >= CLK_HZ: acc <= sum - CLK_HZ and clk_audio toggles.
//   - The sum is computed at ACC_WIDTH+1 bits, so there is no wrap-around.
//   - The half period is floor or ceil of CLK_HZ/(2*AUDIO_RATE) cycles.
//   - The long-term error is zero.
//
//   Push
//   - in_valid && in_ready writes in_data at the tail.
//   - The word is readable as the FIFO head from the next cycle.
//   - in_valid && !in_ready drops the frame and sets overrun.
//
//   Pop
//   - Occurs in the cycle where clk_audio toggles 0->1 (rising toggle).
//   - In that same cycle's edge, out_sample loads the head frame, converted,
//     and sample_tick=1.
//   - A pop when empty sets underrun, and out_sample follows the
//     CONFIGURATION rule. sample_tick still pulses.
//
//   Simultaneous push and pop
//   - Both take effect and fifo_level is unchanged.
//   - If the FIFO is empty, the pop sees empty and underruns. The pushed word
//     is stored; there is no bypass path.
//   - If the FIFO is full, the push is still refused (in_ready=0 is
//     combinational), even though a pop frees a slot that cycle.
//
//   Width conversion, per channel
//   - OUT_WIDTH > IN_WIDTH: left-justify, {in, zeros}.
//   - OUT_WIDTH < IN_WIDTH: keep the top OUT_WIDTH bits.
//   - Equal widths: pass through unchanged.
//
//   Flags
//   - clear_flags takes priority over a flag set in the same cycle.
//
// CONFIGURATION
//   - HDMI_AUDIO_PACER_ZERO_ON_UNDERRUN_EN defined: an underrun pop loads
//     out_sample = 0 (silence).
//   - Undefined (default): an underrun pop holds the previous out_sample.
//   - Sticky flags and tick timing are identical in both builds.
//
// TESTING
//   1. CLK_HZ=27e6, AUDIO_RATE=32000, FIFO kept non-empty for 27000 cycles
//      -> exactly 32 sample_tick pulses.
//   2. Same clocking: every tick spacing is 843 or 844 cycles, and the
//      spacings sum exactly over the window.
//   3. Push frames L=0x1234/R=0x8001 with OUT_WIDTH=24
//      -> the next tick gives out_sample = {0x800100, 0x123400};
//      fifo_level goes 1 -> 0.
//   4. FIFO_DEPTH=8: push 9 frames back-to-back with no tick
//      -> in_ready=0 after the 8th frame, overrun=1, fifo_level=8,
//         and the 9th frame is not stored.
//   5. Empty FIFO at tick -> underrun=1. out_sample holds its last value,
//      or is 0 with the _EN macro. Then pulse clear_flags -> underrun=0.
//   6. Assert resetn=0 mid-stream with fifo_level=5 -> all reset values
//      above; after release, the first tick is at ~422 cycles
//      (clk_audio 0->1 toggle).

Source files
------------

// File: rtl/hdmi_audio_pacer.sv
// hdmi_audio_pacer: NCO-paced audio frame FIFO feeding the hdmi core.
// Define HDMI_AUDIO_PACER_ZERO_ON_UNDERRUN_EN to emit silence on underrun.
module hdmi_audio_pacer #(
    parameter int CLK_HZ     = 27000000,
    parameter int AUDIO_RATE = 32000,
    parameter int CHANNELS   = 2,
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int ACC_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [CHANNELS*IN_WIDTH-1:0]    in_data,
    output logic [CHANNELS*OUT_WIDTH-1:0]   out_sample,
    output logic                            clk_audio,
    output logic                            sample_tick,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            underrun,
    output logic                            overrun,
    input  logic                            clear_flags
);
    localparam int LW = $clog2(FIFO_DEPTH);
    localparam logic [ACC_WIDTH:0] CLK_W  = (ACC_WIDTH+1)'(CLK_HZ);
    localparam logic [ACC_WIDTH:0] STEP_W = (ACC_WIDTH+1)'(2*AUDIO_RATE);
    localparam logic [LW:0]        FULL   = (LW+1)'(FIFO_DEPTH);

    logic [ACC_WIDTH-1:0]          acc;
    logic [ACC_WIDTH:0]            sum;
    logic                          toggle, pop, push, take;
    logic [CHANNELS*IN_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [LW-1:0]                 wr_ptr, rd_ptr;
    logic [CHANNELS*IN_WIDTH-1:0]  head;
    logic [CHANNELS*OUT_WIDTH-1:0] head_conv;

    assign in_ready = fifo_level != FULL;

    always_comb begin
        sum    = {1'b0, acc} + STEP_W;
        toggle = sum >= CLK_W;
        pop    = toggle && !clk_audio;
        push   = in_valid && in_ready;
        take   = pop && fifo_level != '0;
        head   = mem[rd_ptr];
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        if (OUT_WIDTH > IN_WIDTH) begin : g_wide
            assign head_conv[c*OUT_WIDTH +: OUT_WIDTH] =
                {head[c*IN_WIDTH +: IN_WIDTH], {(OUT_WIDTH-IN_WIDTH){1'b0}}};
        end else begin : g_narrow
            assign head_conv[c*OUT_WIDTH +: OUT_WIDTH] =
                head[c*IN_WIDTH + IN_WIDTH - OUT_WIDTH +: OUT_WIDTH];
        end
    end

    // Storage needs no reset: reset clears the pointers, which discards it.
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= in_data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc         <= '0;
            clk_audio   <= 1'b0;
            sample_tick <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            out_sample  <= '0;
            underrun    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            acc         <= ACC_WIDTH'(toggle ? sum - CLK_W : sum);
            clk_audio   <= clk_audio ^ toggle;
            sample_tick <= pop;
            wr_ptr      <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr      <= take ? rd_ptr + 1'b1 : rd_ptr;
            fifo_level  <= fifo_level + (LW+1)'(push) - (LW+1)'(take);
`ifdef HDMI_AUDIO_PACER_ZERO_ON_UNDERRUN_EN
            out_sample  <= take ? head_conv : pop ? '0 : out_sample;
`else
            out_sample  <= take ? head_conv : out_sample;
`endif
            underrun    <= !clear_flags && (underrun || (pop && !take));
            overrun     <= !clear_flags && (overrun || (in_valid && !in_ready));
        end
    end
endmodule

// File: tb/tb_hdmi_audio_pacer.sv
// tb_hdmi_audio_pacer: scoreboard bench for hdmi_audio_pacer (24-bit output build).
module tb_hdmi_audio_pacer;
    localparam int DEPTH = 8;

    logic        clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, clear_flags = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, clk_audio, sample_tick, underrun, overrun;
    logic [47:0] out_sample;
    logic [3:0]  fifo_level;

    hdmi_audio_pacer #(
        .CLK_HZ(27000000), .AUDIO_RATE(32000), .CHANNELS(2), .IN_WIDTH(16),
        .OUT_WIDTH(24), .FIFO_DEPTH(DEPTH), .ACC_WIDTH(32)
    ) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_sample(out_sample), .clk_audio(clk_audio),
        .sample_tick(sample_tick), .fifo_level(fifo_level), .underrun(underrun),
        .overrun(overrun), .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, ticks = 0, first_tick = 0, last_tick = 0;
    logic [47:0] q[$];
    logic [47:0] last_out = '0;
    logic und_m = 1'b0, ovr_m = 1'b0;

    function automatic logic [47:0] conv(input logic [31:0] d);
        return {d[31:16], 8'h00, d[15:0], 8'h00};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        chk("fifo_level", 64'(fifo_level), 64'(q.size()));
        chk("underrun", 64'(underrun), 64'(und_m));
        chk("overrun", 64'(overrun), 64'(ovr_m));
    endtask

    task automatic chk_reset();
        chk("rst_out_sample", 64'(out_sample), 64'h0);
        chk("rst_sample_tick", 64'(sample_tick), 64'h0);
        chk("rst_fifo_level", 64'(fifo_level), 64'h0);
        chk("rst_underrun", 64'(underrun), 64'h0);
        chk("rst_overrun", 64'(overrun), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_clk_audio", 64'(clk_audio), 64'h0);
    endtask

    // One clock: model push/pop/flags around the edge, score any tick.
    task automatic step();
        logic pend, ovs, clr, und_set, t;
        logic [47:0] e, pushed;
        pend = in_valid && (q.size() < DEPTH);
        ovs = in_valid && !pend;
        clr = clear_flags;
        pushed = conv(in_data);
        und_set = 1'b0;
        @(posedge clk); #1;
        cyc++;
        t = sample_tick;
        if (t) begin
            ticks++;
            if (ticks == 1) first_tick = cyc;
            else chk("tick_spacing_ok", 64'((cyc - last_tick == 843) || (cyc - last_tick == 844)), 64'h1);
            last_tick = cyc;
            if (q.size() == 0) begin
                und_set = 1'b0 + 1'b1;
`ifdef HDMI_AUDIO_PACER_ZERO_ON_UNDERRUN_EN
                e = '0;
`else
                e = last_out;
`endif
            end else e = q.pop_front();
            last_out = e;
            chk("out_sample", 64'(out_sample), 64'(e));
        end
        if (pend) q.push_back(pushed);
        und_m = !clr && (und_m || und_set);
        ovr_m = !clr && (ovr_m || ovs);
        if (t) chk_state();
    endtask

    task automatic wait_tick(input int maxc);
        int t0;
        t0 = ticks;
        for (int i = 0; i < maxc && ticks == t0; i++) step();
        chk("tick_within_bound", 64'(ticks != t0), 64'h1);
    endtask

    initial begin
        #23;
        chk_reset();
        @(posedge clk); #1;
        resetn = 1'b1;
        cyc = 0;
        // Steady stream: keep the FIFO topped up for exactly 1 ms of clk.
        for (int i = 0; i < 27000; i++) begin
            in_valid = q.size() < 6;
            in_data = $urandom;
            step();
        end
        in_valid = 1'b0;
        chk("tick_count_1ms", 64'(ticks), 64'd32);
        chk("first_tick_cycle", 64'(first_tick), 64'd422);
        chk("spacing_sum", 64'(last_tick - first_tick), 64'd26157);
        chk_state();

        // Drain, then one empty tick must underrun and hold/zero the output.
        for (int g = 0; g < 10 && q.size() > 0; g++) wait_tick(900);
        wait_tick(900);
        chk("underrun_set", 64'(underrun), 64'h1);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("underrun_cleared", 64'(underrun), 64'h0);

        // Width conversion of a known frame.
        in_data = {16'h8001, 16'h1234};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("level_one", 64'(fifo_level), 64'd1);
        wait_tick(900);
        chk("conv_frame", 64'(out_sample), 64'h800100_123400);
        chk("level_zero", 64'(fifo_level), 64'd0);

        // Nine back-to-back pushes into an 8-deep FIFO.
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data = $urandom;
            if (i == 7) chk("in_ready_before_8th", 64'(in_ready), 64'h1);
            if (i == 8) chk("in_ready_full", 64'(in_ready), 64'h0);
            step();
        end
        in_valid = 1'b0;
        chk("level_full", 64'(fifo_level), 64'd8);
        chk("overrun_set", 64'(overrun), 64'h1);
        chk("in_ready_stays_low", 64'(in_ready), 64'h0);
        for (int i = 0; i < 8; i++) wait_tick(900);
        wait_tick(900);
        chk("underrun_after_drain", 64'(underrun), 64'h1);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk_state();

        // Reset mid-stream with five frames buffered.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data = $urandom;
            step();
        end
        in_valid = 1'b0;
        chk("level_five", 64'(fifo_level), 64'd5);
        #2 resetn = 1'b0;
        #1 chk_reset();
        q.delete();
        last_out = '0;
        und_m = 1'b0;
        ovr_m = 1'b0;
        ticks = 0;
        @(posedge clk); #1;
        resetn = 1'b1;
        cyc = 0;
        wait_tick(900);
        chk("first_tick_after_reset", 64'(first_tick), 64'd422);
        chk("underrun_after_reset_tick", 64'(underrun), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
